player_btn_ctrl: RTL and testbench

//  Input conditioner that sits directly upstream of the player-position stage.

---
 rtl/player_btn_ctrl.sv | 116 +++++++++++
 tb/tb_player_btn_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/player_btn_ctrl.sv
// Button conditioner for the player-position stage: 2-FF sync, debounce,
// last-press-wins arbitration, and move requests that change only on the frame tick.
module player_btn_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_WIDTH       = 18
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Btn_Left_Raw,
    input  logic i_Btn_Right_Raw,
    input  logic i_fTick,
    output logic o_Btn_Left,
    output logic o_Btn_Right
);

    // state | meaning
    // IDLE  | no move requested (neither, or both pressed together)
    // LEFT  | left is the winning button
    // RIGHT | right is the winning button
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Index 0 is the left button, index 1 the right button.
    logic [1:0]           raw;
    logic [1:0]           s1_q;
    logic [1:0]           s2_q;
    logic [1:0]           db_q;
    logic [1:0]           db_d;
    logic [1:0]           db_prev_q;
    logic [1:0]           rise;
    logic [CNT_WIDTH-1:0] cnt_q [2];
    logic [CNT_WIDTH-1:0] cnt_d [2];
    logic                 lvl_l;
    logic                 lvl_r;
    logic                 out_l_q;
    logic                 out_r_q;
    state_t               state_q;

    assign raw   = {i_Btn_Right_Raw, i_Btn_Left_Raw};
    assign rise  = db_q & ~db_prev_q;
    assign lvl_l = db_q[0];
    assign lvl_r = db_q[1];

    always_comb begin
        db_d  = db_q;
        cnt_d = '{default: '0};
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            cnt_q     <= '{default: '0};
            state_q   <= IDLE;
            out_l_q   <= 1'b0;
            out_r_q   <= 1'b0;
        end else begin
            s1_q      <= raw;
            s2_q      <= s1_q;
            db_q      <= db_d;
            cnt_q     <= cnt_d;
            db_prev_q <= db_q;

            case (state_q)
                IDLE: begin
                    if (lvl_l && !lvl_r) begin
                        state_q <= LEFT;
                    end else if (lvl_r && !lvl_l) begin
                        state_q <= RIGHT;
                    end
                end
                LEFT: begin
                    if (rise[1] || (!lvl_l && lvl_r)) begin
                        state_q <= RIGHT;
                    end else if (!lvl_l && !lvl_r) begin
                        state_q <= IDLE;
                    end
                end
                RIGHT: begin
                    if (rise[0] || (!lvl_r && lvl_l)) begin
                        state_q <= LEFT;
                    end else if (!lvl_l && !lvl_r) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Sampled from the registered state, so a visit between ticks is invisible.
            if (i_fTick) begin
                out_l_q <= (state_q == LEFT);
                out_r_q <= (state_q == RIGHT);
            end
        end
    end

    assign o_Btn_Left  = out_l_q;
    assign o_Btn_Right = out_r_q;

endmodule

// File: tb/tb_player_btn_ctrl.sv
// Directed bench for player_btn_ctrl with DEBOUNCE_CYCLES=4 and a tick every 8 clocks.
`timescale 1ns/1ps
module tb_player_btn_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic left_raw = 1'b0;
    logic right_raw = 1'b0;
    logic ftick = 1'b0;
    logic o_left;
    logic o_right;

    int checks = 0;
    int errors = 0;
    int ph = 0;

    player_btn_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(18)) dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_Btn_Left_Raw (left_raw),
        .i_Btn_Right_Raw(right_raw),
        .i_fTick        (ftick),
        .o_Btn_Left     (o_left),
        .o_Btn_Right    (o_right)
    );

    always #5 clk = ~clk;

    // One rising edge; the tick is high on the edge where ph == 7.
    task automatic step();
        ftick = (ph == 7);
        ph = (ph + 1) % 8;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        left_raw = 1'b0;
        right_raw = 1'b0;
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        ph = 0;
    endtask

    initial begin
        #1;
        // Reset state
        do_reset();
        chk("rst_left", o_left, 1'b0);
        chk("rst_right", o_right, 1'b0);
        chk("rst_dbL", dut.db_q[0], 1'b0);

        // 1: held left qualifies after edge 5, output at the tick on edge 7
        left_raw = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("t1_dbL_e%0d", k), dut.db_q[0], logic'(k >= 5));
            if (k >= 6) chk($sformatf("t1_left_e%0d", k), o_left, logic'(k >= 7));
        end
        chk("t1_right", o_right, 1'b0);

        // 2a: a 3-clock pulse is one short of qualifying
        do_reset();
        left_raw = 1'b1;
        run(3);
        left_raw = 1'b0;
        for (int k = 0; k < 14; k++) begin
            step();
            chk($sformatf("t2a_dbL_%0d", k), dut.db_q[0], 1'b0);
        end
        chk("t2a_left", o_left, 1'b0);
        chk("t2a_right", o_right, 1'b0);

        // 2b: bounce 1010 then settle low
        do_reset();
        for (int k = 0; k < 4; k++) begin
            left_raw = (k % 2 == 0);
            step();
        end
        left_raw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("t2b_dbL_%0d", k), dut.db_q[0], 1'b0);
        end
        chk("t2b_left", o_left, 1'b0);

        // 3: last press wins, release falls back to the held button
        do_reset();
        left_raw = 1'b1;
        run(8);
        chk("t3_left_on", o_left, 1'b1);
        chk("t3_right_off", o_right, 1'b0);
        right_raw = 1'b1;
        run(7);
        chk("t3_hold_left_e14", o_left, 1'b1);
        chk("t3_hold_right_e14", o_right, 1'b0);
        step();
        chk("t3_right_e15", o_right, 1'b1);
        chk("t3_left_e15", o_left, 1'b0);
        right_raw = 1'b0;
        run(7);
        chk("t3_hold_right_e22", o_right, 1'b1);
        step();
        chk("t3_left_e23", o_left, 1'b1);
        chk("t3_right_e23", o_right, 1'b0);

        // 4: simultaneous qualify stays idle; releasing right hands over to left
        do_reset();
        left_raw = 1'b1;
        right_raw = 1'b1;
        run(16);
        chk("t4_both_left", o_left, 1'b0);
        chk("t4_both_right", o_right, 1'b0);
        right_raw = 1'b0;
        run(7);
        chk("t4_left_e22", o_left, 1'b0);
        step();
        chk("t4_left_e23", o_left, 1'b1);
        chk("t4_right_e23", o_right, 1'b0);

        // 5: LEFT held during edges 6..9 only, ticks at edges 3 and 11
        do_reset();
        ph = 4;
        left_raw = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 4) left_raw = 1'b0;
            step();
            chk($sformatf("t5_left_e%0d", k), o_left, 1'b0);
        end
        chk("t5_right", o_right, 1'b0);

        // 6: reset mid-hold forces a full re-debounce
        do_reset();
        right_raw = 1'b1;
        run(8);
        chk("t6_right_on", o_right, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_left", o_left, 1'b0);
        chk("t6_rst_right", o_right, 1'b0);
        run(7);
        chk("t6_right_e15", o_right, 1'b0);
        run(7);
        chk("t6_right_e22", o_right, 1'b0);
        step();
        chk("t6_right_e23", o_right, 1'b1);
        chk("t6_left_e23", o_left, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
